// File: rtl/eep_loader.sv
// Boot loader for the eep core: takes a length-prefixed byte stream, writes little-endian
// 16-bit words into code memory from address 0 and releases the core once the checksum matches.
module eep_loader #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int CODE_DEPTH  = 65536
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   cm_wen,
    output logic [ADDR_WIDTH-1:0]  cm_addr,
    output logic [INSTR_WIDTH-1:0] cm_din,
    output logic                   cpu_run,
    output logic                   load_err,
    output logic [16:0]            words_loaded,
    output logic [2:0]             dbg_state
);

    // Handshake: a byte is consumed on a rising edge where in_valid && in_ready; in_ready is
    // a registered copy of "state is not terminal" and never looks at in_valid.
    typedef enum logic [2:0] {
        S_HDR_LO = 3'd0,
        S_HDR_HI = 3'd1,
        S_DAT_LO = 3'd2,
        S_DAT_HI = 3'd3,
        S_CHECK  = 3'd4,
        S_RUN    = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [16:0] DEPTH = 17'(CODE_DEPTH);

    state_t                   state_q;
    logic [15:0]              len_q;
    logic [7:0]               sum_q;
    logic [7:0]               lo_q;
    logic [16:0]              words_q;
    logic                     in_ready_q;
    logic                     cm_wen_q;
    logic [ADDR_WIDTH-1:0]    cm_addr_q;
    logic [INSTR_WIDTH-1:0]   cm_din_q;
    logic                     cpu_run_q;
    logic                     load_err_q;

    logic                     accept;
    logic [15:0]              len_d;
    logic [7:0]               sum_d;
    logic [16:0]              words_d;

    assign accept  = in_valid && in_ready_q;
    assign len_d   = {in_data, len_q[7:0]};
    assign sum_d   = sum_q + in_data;
    assign words_d = words_q + 17'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_HDR_LO;
            len_q      <= '0;
            sum_q      <= '0;
            lo_q       <= '0;
            words_q    <= '0;
            in_ready_q <= 1'b1;
            cm_wen_q   <= 1'b0;
            cm_addr_q  <= '0;
            cm_din_q   <= '0;
            cpu_run_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cm_wen_q <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    S_HDR_LO: begin
                        len_q[7:0] <= in_data;
                        sum_q      <= sum_d;
                        state_q    <= S_HDR_HI;
                    end
                    S_HDR_HI: begin
                        len_q <= len_d;
                        sum_q <= sum_d;
                        if ({1'b0, len_d} > DEPTH) begin
                            state_q    <= S_ERROR;
                            in_ready_q <= 1'b0;
                            load_err_q <= 1'b1;
                        end else if (len_d == 16'd0) begin
                            state_q <= S_CHECK;
                        end else begin
                            state_q <= S_DAT_LO;
                        end
                    end
                    S_DAT_LO: begin
                        lo_q    <= in_data;
                        sum_q   <= sum_d;
                        state_q <= S_DAT_HI;
                    end
                    S_DAT_HI: begin
                        // Address is the pre-increment count, so the first word lands at 0.
                        sum_q     <= sum_d;
                        cm_wen_q  <= 1'b1;
                        cm_addr_q <= ADDR_WIDTH'(words_q);
                        cm_din_q  <= INSTR_WIDTH'({in_data, lo_q});
                        words_q   <= words_d;
                        state_q   <= (words_d == {1'b0, len_q}) ? S_CHECK : S_DAT_LO;
                    end
                    S_CHECK: begin
                        in_ready_q <= 1'b0;
                        if (in_data == sum_q) begin
                            state_q   <= S_RUN;
                            cpu_run_q <= 1'b1;
                        end else begin
                            state_q    <= S_ERROR;
                            load_err_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign cm_wen       = cm_wen_q;
    assign cm_addr      = cm_addr_q;
    assign cm_din       = cm_din_q;
    assign cpu_run      = cpu_run_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_eep_loader.sv
// Directed bench for eep_loader: a default-depth instance for the load scenarios and a
// CODE_DEPTH=4 instance for the length-overflow and exact-fit cases.
module tb_eep_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        v0 = 1'b0;
    logic [7:0]  d0 = 8'h00;
    logic        rdy0, wen0, run0, err0;
    logic [15:0] addr0, din0;
    logic [16:0] words0;
    logic [2:0]  st0;

    logic        v1 = 1'b0;
    logic [7:0]  d1 = 8'h00;
    logic        rdy1, wen1, run1, err1;
    logic [15:0] addr1, din1;
    logic [16:0] words1;
    logic [2:0]  st1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          got_cyc_q[$];
    logic [31:0] got1_q[$];

    eep_loader u_dut (
        .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0), .in_ready(rdy0),
        .cm_wen(wen0), .cm_addr(addr0), .cm_din(din0), .cpu_run(run0),
        .load_err(err0), .words_loaded(words0), .dbg_state(st0)
    );

    eep_loader #(.CODE_DEPTH(4)) u_small (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
        .cm_wen(wen1), .cm_addr(addr1), .cm_din(din1), .cpu_run(run1),
        .load_err(err1), .words_loaded(words1), .dbg_state(st1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wen0 === 1'b1) begin
            got_q.push_back({addr0, din0});
            got_cyc_q.push_back(cyc);
        end
        if (wen1 === 1'b1) got1_q.push_back({addr1, din1});
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_cyc_q.delete();
        got1_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
    endtask

    // Offers one byte and returns 1 time unit after the edge that consumed it.
    task automatic send(input bit sel, input logic [7:0] b);
        int n = 0;
        if (sel) begin v1 = 1'b1; d1 = b; end
        else     begin v0 = 1'b1; d0 = b; end
        while (!(sel ? rdy1 : rdy0) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) chk("send_ready", {31'd0, (sel ? rdy1 : rdy0)}, 32'd1);
        else begin
            @(posedge clk);
            #1;
        end
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic check_writes(input string tag, input bit sel);
        int n;
        n = sel ? got1_q.size() : got_q.size();
        chk({tag, "_count"}, n, exp_q.size());
        foreach (exp_q[i]) begin
            if (i < n) chk({tag, "_wr"}, sel ? got1_q[i] : got_q[i], exp_q[i]);
        end
    endtask

    task automatic send_nominal(input logic [7:0] chk_byte);
        send(0, 8'h02); send(0, 8'h00);
        send(0, 8'h34); send(0, 8'h12);
        send(0, 8'hCD); send(0, 8'hAB);
        send(0, chk_byte);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready", rdy0, 1);
        chk("rst_cm_wen", wen0, 0);
        chk("rst_cm_addr", addr0, 0);
        chk("rst_cm_din", din0, 0);
        chk("rst_cpu_run", run0, 0);
        chk("rst_load_err", err0, 0);
        chk("rst_words", words0, 0);
        chk("rst_state", st0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_q();

        // Nominal load: 02 00 34 12 CD AB C0
        exp_q.push_back({16'd0, 16'h1234});
        exp_q.push_back({16'd1, 16'hABCD});
        t0 = cyc;
        send_nominal(8'hC0);
        chk("nom_cpu_run", run0, 1);
        chk("nom_words", words0, 2);
        chk("nom_load_err", err0, 0);
        chk("nom_in_ready", rdy0, 0);
        check_writes("nom", 0);
        if (got_cyc_q.size() >= 2) begin
            chk("nom_wr0_cycle", got_cyc_q[0] - t0, 4);
            chk("nom_wr_gap", got_cyc_q[1] - got_cyc_q[0], 2);
        end

        // Bad checksum: C1 instead of C0
        do_reset();
        exp_q.push_back({16'd0, 16'h1234});
        exp_q.push_back({16'd1, 16'hABCD});
        send_nominal(8'hC1);
        chk("bad_load_err", err0, 1);
        chk("bad_cpu_run", run0, 0);
        chk("bad_in_ready", rdy0, 0);
        v0 = 1'b1;
        d0 = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        v0 = 1'b0;
        chk("bad_post_words", words0, 2);
        chk("bad_post_state", st0, 6);
        chk("bad_post_in_ready", rdy0, 0);
        check_writes("bad", 0);

        // Empty image
        do_reset();
        send(0, 8'h00); send(0, 8'h00); send(0, 8'h00);
        chk("empty_cpu_run", run0, 1);
        chk("empty_words", words0, 0);
        chk("empty_load_err", err0, 0);
        check_writes("empty", 0);

        // Overflow on the CODE_DEPTH=4 instance
        do_reset();
        send(1, 8'h05);
        chk("ovf_err_early", err1, 0);
        send(1, 8'h00);
        chk("ovf_load_err", err1, 1);
        chk("ovf_in_ready", rdy1, 0);
        chk("ovf_cpu_run", run1, 0);
        chk("ovf_state", st1, 6);
        check_writes("ovf", 1);

        // Exact fit on the CODE_DEPTH=4 instance: N=4, checksum 0x68
        do_reset();
        exp_q.push_back({16'd0, 16'h2211});
        exp_q.push_back({16'd1, 16'h4433});
        exp_q.push_back({16'd2, 16'h6655});
        exp_q.push_back({16'd3, 16'h8877});
        send(1, 8'h04); send(1, 8'h00);
        send(1, 8'h11); send(1, 8'h22); send(1, 8'h33); send(1, 8'h44);
        send(1, 8'h55); send(1, 8'h66); send(1, 8'h77); send(1, 8'h88);
        send(1, 8'h68);
        chk("fit_cpu_run", run1, 1);
        chk("fit_load_err", err1, 0);
        chk("fit_words", words1, 4);
        check_writes("fit", 1);

        // Stalled source: 3 idle cycles between 34 and 12
        do_reset();
        exp_q.push_back({16'd0, 16'h1234});
        exp_q.push_back({16'd1, 16'hABCD});
        t0 = cyc;
        send(0, 8'h02); send(0, 8'h00); send(0, 8'h34);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("stall_no_write", got_q.size(), 0);
        send(0, 8'h12); send(0, 8'hCD); send(0, 8'hAB); send(0, 8'hC0);
        chk("stall_cpu_run", run0, 1);
        chk("stall_words", words0, 2);
        check_writes("stall", 0);
        if (got_cyc_q.size() >= 2) begin
            chk("stall_wr0_cycle", got_cyc_q[0] - t0, 7);
            chk("stall_wr_gap", got_cyc_q[1] - got_cyc_q[0], 2);
        end

        // Reset mid-load, asserted while the first write strobe is up
        do_reset();
        send(0, 8'h02); send(0, 8'h00); send(0, 8'h34); send(0, 8'h12);
        chk("mid_wen_before", wen0, 1);
        chk("mid_words_before", words0, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_in_ready", rdy0, 1);
        chk("mid_cm_wen", wen0, 0);
        chk("mid_cm_addr", addr0, 0);
        chk("mid_cm_din", din0, 0);
        chk("mid_words", words0, 0);
        chk("mid_state", st0, 0);
        chk("mid_cpu_run", run0, 0);
        chk("mid_load_err", err0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_q();
        exp_q.push_back({16'd0, 16'h1234});
        exp_q.push_back({16'd1, 16'hABCD});
        send_nominal(8'hC0);
        chk("mid_final_run", run0, 1);
        chk("mid_final_err", err0, 0);
        chk("mid_final_words", words0, 2);
        check_writes("mid", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
